// File: rtl/serial_pattern_generator.sv
// serial_pattern_generator
// Shifts a loaded parallel pattern out MSB-first on X, one bit per enabled
// clock, with a one-cycle valid strobe per new bit, one-shot or continuous
// repeat, and a done pulse at the end of every pass.
module serial_pattern_generator #(
  parameter int WIDTH = 44,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  input  logic             start,
  input  logic             en,
  input  logic             rep,
  output logic             X,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [CNT_W-1:0] slen;

  // Requested length clipped to the shadow width.
  logic [CNT_W-1:0] len_sat;
  // Pattern/length a start would use this cycle: a same-cycle load wins.
  logic [WIDTH-1:0] eff_pat;
  logic [CNT_W-1:0] eff_len;

  // Resolve saturation and the load/start bypass.
  always_comb begin
    len_sat = (len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : len;
    eff_pat = load ? pattern : shadow;
    eff_len = load ? len_sat : slen;
  end

  // Control FSM; every output is a register. The shadow is only read by
  // index (bit_cnt), so repeat passes need no reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shadow  <= '0;
      slen    <= '0;
      X       <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          X       <= 1'b0;
          busy    <= 1'b0;
          bit_cnt <= '0;
          if (load) begin
            shadow <= pattern;
            slen   <= len_sat;
          end
          // First bit goes out immediately, independent of en.
          if (start && (eff_len != '0)) begin
            state   <= SHIFT;
            X       <= eff_pat[eff_len - CNT_W'(1)];
            bit_cnt <= eff_len - CNT_W'(1);
            valid   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (en) begin
            if (bit_cnt != '0) begin
              X       <= shadow[bit_cnt - CNT_W'(1)];
              bit_cnt <= bit_cnt - CNT_W'(1);
              valid   <= 1'b1;
            end else if (rep) begin
              // Wrap straight back to the MSB: no gap bit between passes.
              X       <= shadow[slen - CNT_W'(1)];
              bit_cnt <= slen - CNT_W'(1);
              valid   <= 1'b1;
              done    <= 1'b1;
            end else begin
              state <= IDLE;
              X     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_pattern_generator.md
Name: serial_pattern_generator

Overview:
- Serial bit-stream transmitter for the lab sequence-detector datapath.
- Loads a parallel pattern of up to WIDTH bits and shifts it out MSB-first on X, one bit per enabled clock.
- Flags each new bit with a single-cycle valid strobe, so a sequence detector can be driven in hardware instead of from a bench loop.
- Supports one-shot and continuous repeat, start/done handshake, and a step enable for slow or paused streaming.

Parameters:
WIDTH, 44, maximum pattern length in bits
CNT_W, 6, width of length/count fields; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-low reset (0 = reset)
load  in  1  capture pattern and len into shadow registers
pattern  in  WIDTH  pattern bits; bit len-1 is sent first, bit 0 last
len  in  CNT_W  number of bits to send, 0..WIDTH
start  in  1  begin transmission
en  in  1  step enable; advances to the next bit on edges where en=1
rep  in  1  1 = wrap to MSB after the last bit, 0 = one-shot
X  out  1  serial output bit (registered)
valid  out  1  1 for exactly one cycle per newly presented bit
busy  out  1  1 while in SHIFT
done  out  1  one-cycle pulse at the end of each pass
bit_cnt  out  CNT_W  bits remaining after the current X

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE immediately.
  - X, valid, busy, done and bit_cnt all go to 0.
  - Shadow pattern and shadow length clear to 0.
  - This also applies mid-stream; after reset releases, the block waits for a new load and start.
- States: IDLE, SHIFT. All outputs are registered.
- load:
  - Honoured only in IDLE.
  - Ignored while busy=1.
  - A len greater than WIDTH saturates to WIDTH.
- start:
  - In IDLE with an effective length of 0, start is ignored and the block stays IDLE with done=0.
  - In IDLE with a nonzero length, at edge k the block enters SHIFT. After edge k: X = shadow[len-1], valid=1, busy=1, bit_cnt=len-1.
  - The first bit does not wait for en.
  - load and start in the same cycle: the newly loaded pattern and length are used.
  - start while busy=1 is ignored.
- Advancing in SHIFT, at each edge:
  - en=0: X and bit_cnt hold, valid=0.
  - en=1 and bit_cnt>0: X = next lower pattern bit, bit_cnt decrements, valid=1.
- End of pass, at an edge with en=1 and bit_cnt=0:
  - rep=0: go to IDLE with done=1 for one cycle, valid=0, busy=0, X=0.
  - rep=1: stay in SHIFT, X = shadow[len-1], bit_cnt=len-1, valid=1, done=1 for one cycle. There is no gap bit between passes.
- rep is sampled only at the end-of-pass edge. Clearing rep mid-pass ends the stream after the current pass.
- Latency and throughput:
  - First bit appears 1 clock after start.
  - With en held at 1, a pass of len bits occupies len consecutive cycles.
  - done follows the last bit by exactly 1 cycle.
- done is never asserted together with busy=0 in any cycle other than the end-of-pass cycle.
- Internals: a WIDTH-bit shadow register and a down-counter. Bit select uses the counter index; the shadow is not destroyed, so repeat needs no reload.

Test Plan:
- Reset values: hold reset=0 with random inputs -> X=0, valid=0, busy=0, done=0, bit_cnt=0; pull reset low mid-stream -> all outputs 0 asynchronously, before the next clk edge.
- One-shot stream:
  - Stimulus: load pattern[5:0]=6'b101101, len=6, en=1, rep=0, then start.
  - Response: X = 1,0,1,1,0,1 on 6 consecutive cycles, valid=1 on each, bit_cnt = 5..0, then done=1 for one cycle with busy=0.
- Repeat mode: same pattern with rep=1 and 14 enabled cycles -> X = 101101 101101 10; done pulses after bit 6 and bit 12; busy stays 1.
- Step enable: en toggling 1,0,0,1,... -> valid pulses only after en=1 edges; X holds across en=0 cycles; still exactly 6 valid pulses for len=6.
- Boundaries:
  - len=0 then start -> busy stays 0, no done.
  - len=50 -> saturates to 44; exactly 44 valid bits.
  - start and load during busy -> ignored; stream unchanged.
- load+start in the same cycle with a new pattern 3'b110, len=3 -> first X=1 appears the next cycle, followed by 1, 0.
